// File: rtl/starfield_speed_ctrl_if.sv
// ---------------------------------------------------------------------------
// starfield_speed_ctrl_if
// Bus bundle around the starfield speed sequencer.
//   cpu_wr   : CPU register write strobe
//   cpu_addr : register select (0 target, 1 interval, 2 ctrl, 3 reserved)
//   cpu_din  : CPU write data
//   sf_data  : data to the starfield data_in; bits [7:4] are always 0
//   sf_write : one-cycle write strobe to the starfield
// The master modport is the system side (CPU driving the register bus,
// starfield receiving the writes). The slave modport is the sequencer.
// ---------------------------------------------------------------------------
interface starfield_speed_ctrl_if;
   logic       cpu_wr;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_din;
   logic [7:0] sf_data;
   logic       sf_write;

   modport master (
      output cpu_wr, cpu_addr, cpu_din,
      input  sf_data, sf_write
   );

   modport slave (
      input  cpu_wr, cpu_addr, cpu_din,
      output sf_data, sf_write
   );
endinterface

// File: rtl/starfield_speed_ctrl.sv
// ---------------------------------------------------------------------------
// starfield_speed_ctrl
// Sole writer of the starfield speed. Holds a CPU-programmed target and ramp
// interval and walks the 4-bit speed one unit every `interval` frame ticks
// (or jumps straight to the target when interval is 0). Every speed change
// is a single registered write strobe on the bus.
//   clk          : system clock
//   rst          : synchronous, active-high reset
//   vblank       : vertical blank level; its rising edge is one frame tick
//   bus          : CPU register bus in, starfield write port out (slave)
//   cur_speed    : speed last written to the starfield
//   target_speed : programmed target
//   ramping      : high while a ramp is in progress (WAIT or STEP)
// ---------------------------------------------------------------------------
module starfield_speed_ctrl #(
   parameter logic [3:0] INIT_SPEED = 4'd0,
   parameter int         DIV_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         vblank,
   starfield_speed_ctrl_if.slave        bus,
   output logic [3:0]                   cur_speed,
   output logic [3:0]                   target_speed,
   output logic                         ramping
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_WAIT,
      S_STEP
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] interval;
   logic [DIV_W-1:0] frame_cnt, frame_cnt_nxt;
   logic             enable;
   logic             vblank_q;
   logic             tick;
   logic             force_pend, force_pend_nxt;
   logic [3:0]       cur_nxt;
   logic [3:0]       step_val;
   logic [3:0]       wr_val;
   logic             wr_nxt;
   logic             try_step;
   logic             wr_target, wr_interval, wr_ctrl;
   logic             force_req, force_hit, write_busy;

   // ------------------------------------------------------------------
   // CPU registers and frame tick
   // ------------------------------------------------------------------
   assign wr_target   = bus.cpu_wr && (bus.cpu_addr == 2'd0);
   assign wr_interval = bus.cpu_wr && (bus.cpu_addr == 2'd1);
   assign wr_ctrl     = bus.cpu_wr && (bus.cpu_addr == 2'd2);
   assign force_req   = wr_ctrl && bus.cpu_din[1];

   assign tick = vblank && !vblank_q;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every flop samples the
      // values that existed before the clock edge.
      if (rst) begin
         target_speed <= INIT_SPEED;
         interval     <= '0;
         enable       <= 1'b0;
         vblank_q     <= 1'b0;
      end else begin
         vblank_q <= vblank;
         if (wr_target)   target_speed <= bus.cpu_din[3:0];
         if (wr_interval) interval     <= DIV_W'(bus.cpu_din);
         if (wr_ctrl)     enable       <= bus.cpu_din[0];
      end
   end

   // Next speed: a jump lands on the target, a ramp moves one unit toward
   // it. Only used when cur_speed differs from the target, so it never wraps.
   always_comb begin
      if (interval == '0)
         step_val = target_speed;
      else if (cur_speed < target_speed)
         step_val = cur_speed + 4'd1;
      else
         step_val = cur_speed - 4'd1;
   end

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can infer a latch.
      state_nxt      = state;
      frame_cnt_nxt  = frame_cnt;
      cur_nxt        = cur_speed;
      wr_nxt         = 1'b0;
      wr_val         = cur_speed;
      force_pend_nxt = 1'b0;
      try_step       = 1'b0;

      unique case (state)
         S_INIT: begin
            wr_nxt    = 1'b1;
            wr_val    = INIT_SPEED;
            cur_nxt   = INIT_SPEED;
            state_nxt = S_IDLE;
         end

         S_IDLE: begin
            if (enable && (cur_speed != target_speed)) begin
               if (interval == '0) begin
                  try_step = 1'b1;
               end else begin
                  frame_cnt_nxt = interval;
                  state_nxt     = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (tick) begin
               if (frame_cnt == DIV_W'(1))
                  try_step = 1'b1;
               else
                  frame_cnt_nxt = frame_cnt - DIV_W'(1);
            end
         end

         S_STEP: begin
            if (!bus.sf_write) begin
               // Second cycle of a back-to-back jump: the strobe from the
               // previous step has dropped, so the next one may be issued.
               try_step = 1'b1;
            end else if (enable && (cur_speed != target_speed)) begin
               if (interval == '0) begin
                  state_nxt = S_STEP;
               end else begin
                  frame_cnt_nxt = interval;
                  state_nxt     = S_WAIT;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
      endcase

      // Step entry re-checks against the live target: a target rewritten
      // during WAIT may already equal the current speed.
      if (try_step) begin
         if (cur_speed == target_speed) begin
            state_nxt = S_IDLE;
         end else begin
            wr_nxt    = 1'b1;
            wr_val    = step_val;
            cur_nxt   = step_val;
            state_nxt = S_STEP;
         end
      end

      // Force overrides any step or tick. If a strobe is already on the bus
      // (or the INIT write is going out) it is held for one cycle so strobes
      // never sit back to back.
      force_hit  = force_req || force_pend;
      write_busy = bus.sf_write || (state == S_INIT);
      if (force_hit) begin
         if (write_busy) begin
            force_pend_nxt = 1'b1;
         end else begin
            wr_nxt    = 1'b1;
            wr_val    = target_speed;
            cur_nxt   = target_speed;
            state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_INIT;
         frame_cnt    <= '0;
         cur_speed    <= INIT_SPEED;
         force_pend   <= 1'b0;
         bus.sf_write <= 1'b0;
         bus.sf_data  <= 8'h00;
      end else begin
         state        <= state_nxt;
         frame_cnt    <= frame_cnt_nxt;
         cur_speed    <= cur_nxt;
         force_pend   <= force_pend_nxt;
         bus.sf_write <= wr_nxt;
         if (wr_nxt) bus.sf_data <= {4'b0000, wr_val};
      end
   end

   assign ramping = (state == S_WAIT) || (state == S_STEP);

endmodule

// File: tb/tb_starfield_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_starfield_speed_ctrl
// Scoreboard bench for starfield_speed_ctrl. The stimulus process updates a
// transaction-level model of the speed register (target, interval, enable,
// ticks since the last step) and pushes every starfield write it predicts,
// with the cycle it must appear on, into a queue. A monitor pops and
// compares whenever the DUT strobes sf_write.
// ---------------------------------------------------------------------------
module tb_starfield_speed_ctrl;

   localparam logic [3:0] TB_INIT = 4'd0;

   logic clk;
   logic rst;
   logic vblank;
   logic [3:0] cur_speed;
   logic [3:0] target_speed;
   logic       ramping;

   starfield_speed_ctrl_if bus();

   starfield_speed_ctrl #(
      .INIT_SPEED (TB_INIT),
      .DIV_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vblank       (vblank),
      .bus          (bus),
      .cur_speed    (cur_speed),
      .target_speed (target_speed),
      .ramping      (ramping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: what the speed register should do, in terms of
   // register values and frame ticks counted since the last step.
   // ------------------------------------------------------------------
   typedef struct {
      int data;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   m_cur, m_target, m_interval, m_ticks;
   bit   m_enable, m_active;

   function automatic void expect_write(input int d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset(input int r);
      m_cur      = int'(TB_INIT);
      m_target   = int'(TB_INIT);
      m_interval = 0;
      m_ticks    = 0;
      m_enable   = 1'b0;
      m_active   = 1'b0;
      expect_write(int'(TB_INIT), r + 1);
   endfunction

   // Enabled with a speed mismatch: jump at once, or start counting ticks.
   function automatic void model_start(input int w);
      if (m_enable && (m_cur != m_target)) begin
         if (m_interval == 0) begin
            expect_write(m_target, w + 1);
            m_cur = m_target;
         end else begin
            m_active = 1'b1;
            m_ticks  = 0;
         end
      end
   endfunction

   function automatic void model_cpu(input logic [1:0] a, input logic [7:0] d,
                                     input int w);
      case (a)
         2'd0: begin
            m_target = int'(d[3:0]);
            if (!m_active) model_start(w);
         end
         2'd1: m_interval = int'(d);
         2'd2: begin
            m_enable = d[0];
            if (d[1]) begin
               expect_write(m_target, w);
               m_cur    = m_target;
               m_active = 1'b0;
            end else if (!m_enable) begin
               m_active = 1'b0;
            end else if (!m_active) begin
               model_start(w);
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void model_tick(input int p);
      int nv;
      if (m_active) begin
         m_ticks++;
         if (m_ticks == m_interval) begin
            if (m_cur == m_target) begin
               m_active = 1'b0;
            end else begin
               nv = (m_cur < m_target) ? m_cur + 1 : m_cur - 1;
               expect_write(nv, p + 1);
               m_cur   = nv;
               m_ticks = 0;
               if (m_cur == m_target) m_active = 1'b0;
            end
         end
      end
   endfunction

   // ------------------------------------------------------------------
   // Stimulus tasks
   // ------------------------------------------------------------------
   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      int w;
      @(posedge clk); #1;
      bus.cpu_wr   = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_din  = d;
      @(posedge clk); #1;
      bus.cpu_wr = 1'b0;
      w = cyc;
      model_cpu(a, d, w);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic vblank_pulse(input int hi, input int lo);
      @(posedge clk); #1;
      vblank = 1'b1;
      model_tick(cyc);
      repeat (hi) @(posedge clk);
      #1 vblank = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic check_status();
      check("cur_speed",    32'(cur_speed),    32'(m_cur));
      check("target_speed", 32'(target_speed), 32'(m_target));
      check("ramping",      32'(ramping),      32'(m_active));
      check("writes_seen",  32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst        = 1'b1;
      vblank     = 1'b0;
      bus.cpu_wr = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check("rst_sf_write", 32'(bus.sf_write),  32'd0);
      check("rst_sf_data",  32'(bus.sf_data),   32'd0);
      check("rst_cur",      32'(cur_speed),     32'(TB_INIT));
      check("rst_target",   32'(target_speed),  32'(TB_INIT));
      check("rst_ramping",  32'(ramping),       32'd0);
      rst = 1'b0;
      model_reset(cyc);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Monitor: every strobe must match the head of the scoreboard.
   // ------------------------------------------------------------------
   bit mon_prev = 1'b0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.sf_write === 1'b1) begin
            check("write_spacing", 32'(mon_prev), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, expected no write",
                        bus.sf_data, cyc);
            end else begin
               e = exp_q.pop_front();
               check("write_data",      32'(bus.sf_data), 32'(e.data));
               check("write_cycle",     32'(cyc),         32'(e.cyc));
               check("cur_after_write", 32'(cur_speed),   32'(e.data));
            end
         end
         mon_prev = (bus.sf_write === 1'b1);
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached after %0d checks, expected $finish", checks);
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin : stim
      logic [7:0] d;
      rst          = 1'b1;
      vblank       = 1'b0;
      bus.cpu_wr   = 1'b0;
      bus.cpu_addr = 2'd0;
      bus.cpu_din  = 8'h00;

      // Reset: one INIT write, then silence while idle.
      do_reset(3);
      repeat (5) vblank_pulse(1, 1);
      cpu_write(2'd3, 8'hFF);
      check_status();

      // Ramp up 0 -> 3 at interval 2 over 8 frames.
      cpu_write(2'd1, 8'd2);
      cpu_write(2'd2, 8'h01);
      cpu_write(2'd0, 8'h03);
      check_status();
      for (int k = 0; k < 8; k++) begin
         vblank_pulse(2, 2);
         check_status();
      end

      // Jump to 9.
      cpu_write(2'd1, 8'd0);
      cpu_write(2'd0, 8'h09);
      check_status();

      // Reversal: back to 0 by force, ramp toward 10, retarget to 2 at 5.
      cpu_write(2'd2, 8'h00);
      cpu_write(2'd0, 8'h00);
      cpu_write(2'd2, 8'h02);
      cpu_write(2'd1, 8'd1);
      cpu_write(2'd0, 8'h0A);
      cpu_write(2'd2, 8'h01);
      check_status();
      for (int k = 0; k < 20 && m_cur != 5; k++) vblank_pulse(1, 1);
      check("reversal_reach5", 32'(cur_speed), 32'd5);
      cpu_write(2'd0, 8'h02);
      for (int k = 0; k < 5; k++) begin
         vblank_pulse(1, 2);
         check_status();
      end

      // Force to 15 during WAIT with enable kept on.
      cpu_write(2'd1, 8'd3);
      cpu_write(2'd0, 8'h0C);
      vblank_pulse(1, 1);
      cpu_write(2'd0, 8'h0F);
      check("force_in_wait", 32'(ramping), 32'd1);
      cpu_write(2'd2, 8'h03);
      check_status();
      repeat (4) vblank_pulse(1, 1);
      check_status();

      // Force during WAIT while clearing enable.
      cpu_write(2'd0, 8'h0A);
      vblank_pulse(1, 1);
      cpu_write(2'd2, 8'h02);
      check_status();
      repeat (4) vblank_pulse(1, 1);
      check_status();

      // Long vblank: one tick only.
      cpu_write(2'd1, 8'd1);
      cpu_write(2'd0, 8'h0C);
      cpu_write(2'd2, 8'h01);
      vblank_pulse(50, 2);
      check_status();
      vblank_pulse(2, 2);
      check_status();

      // Reset in the middle of WAIT.
      cpu_write(2'd1, 8'd3);
      cpu_write(2'd0, 8'h04);
      vblank_pulse(1, 1);
      check_status();
      do_reset(2);
      repeat (3) vblank_pulse(1, 1);
      check_status();

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1: cpu_write(2'd0, 8'($urandom));
            2: if (!m_active) cpu_write(2'd1, 8'($urandom_range(0, 3)));
            3: begin
               d    = 8'($urandom);
               d[1] = 1'b0;
               d[0] = ($urandom_range(0, 3) != 0);
               cpu_write(2'd2, d);
            end
            4: begin
               d    = 8'($urandom);
               d[1] = ($urandom_range(0, 3) == 0);
               d[0] = 1'($urandom);
               cpu_write(2'd2, d);
            end
            5: cpu_write(2'd3, 8'($urandom));
            default: vblank_pulse($urandom_range(1, 4), $urandom_range(1, 3));
         endcase
         check_status();
      end

      repeat (10) @(posedge clk);
      #1;
      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
